// File: rtl/eth_pcs_rx_block_lock_mlane.sv
// Multi-lane PCS receive block lock: each lane independently hunts for a 2-bit sync
// header alignment, requests gearbox slips, and reports lock once a full window is clean.
module eth_pcs_rx_block_lock_mlane #(
    parameter int N_LANES     = 4,
    parameter int SH_VAL_TH   = 64,
    parameter int SH_INVAL_TH = 16,
    parameter int SLIP_WAIT   = 4,
    localparam int W_SYNC     = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N_LANES-1:0]     i_valid,
    input  logic [N_LANES*W_SYNC-1:0] i_sync_hdr,
    output logic [N_LANES-1:0]     o_slip,
    output logic [N_LANES-1:0]     o_blk_lock,
    output logic                   o_all_lock,
    output logic [N_LANES*8-1:0]   o_slip_cnt,
    output logic [N_LANES*2-1:0]   o_dbg_state
);

    localparam logic [W_SYNC-1:0] SYNC_DATA = 2'b01;
    localparam logic [W_SYNC-1:0] SYNC_CTRL = 2'b10;

    localparam int SH_W  = $clog2(SH_VAL_TH + 1);
    localparam int INV_W = $clog2(SH_INVAL_TH + 1);
    localparam int WT_W  = $clog2(SLIP_WAIT + 1);

    localparam logic [SH_W-1:0]  SH_LAST  = SH_W'(SH_VAL_TH - 1);
    localparam logic [INV_W-1:0] INV_LAST = INV_W'(SH_INVAL_TH - 1);
    localparam logic [WT_W-1:0]  WT_LAST  = WT_W'(SLIP_WAIT - 1);

    typedef enum logic [1:0] {
        ST_LOCK_INIT = 2'd0,
        ST_TEST      = 2'd1,
        ST_SLIP_WAIT = 2'd2
    } state_t;

    if (N_LANES < 1 || N_LANES > 20 || SH_INVAL_TH < 1 || SH_INVAL_TH > SH_VAL_TH || SLIP_WAIT < 1) begin : g_param_check
        $error("eth_pcs_rx_block_lock_mlane: illegal parameter combination");
    end

    logic [N_LANES-1:0] lock_nxt;
    logic               all_lock_q;

    for (genvar g = 0; g < N_LANES; g++) begin : g_lane
        state_t            state_q, state_n;
        logic [SH_W-1:0]   sh_q, sh_n;
        logic [INV_W-1:0]  inv_q, inv_n;
        logic [WT_W-1:0]   wt_q, wt_n;
        logic              lock_q, lock_n;
        logic              slip_q, slip_n;
        logic [7:0]        scnt_q, scnt_n;
        logic [W_SYNC-1:0] hdr;
        logic              hdr_ok;
        logic              vld;

        assign hdr    = i_sync_hdr[W_SYNC*g +: W_SYNC];
        assign vld    = i_valid[g];
        assign hdr_ok = (hdr == SYNC_DATA) || (hdr == SYNC_CTRL);

        always_ff @(posedge i_clk) begin : lane_reg
            if (i_reset) begin
                state_q <= ST_LOCK_INIT;
                sh_q    <= '0;
                inv_q   <= '0;
                wt_q    <= '0;
                lock_q  <= 1'b0;
                slip_q  <= 1'b0;
                scnt_q  <= '0;
            end else begin
                state_q <= state_n;
                sh_q    <= sh_n;
                inv_q   <= inv_n;
                wt_q    <= wt_n;
                lock_q  <= lock_n;
                slip_q  <= slip_n;
                scnt_q  <= scnt_n;
            end
        end

        // Invalid beats a window boundary: an invalid header that reaches the
        // threshold slips even if it is also the last header of the window.
        always_comb begin : lane_next
            state_n = state_q;
            sh_n    = sh_q;
            inv_n   = inv_q;
            wt_n    = wt_q;
            lock_n  = lock_q;
            slip_n  = 1'b0;
            case (state_q)
                ST_LOCK_INIT: begin
                    sh_n    = '0;
                    inv_n   = '0;
                    wt_n    = '0;
                    state_n = ST_TEST;
                end
                ST_TEST: begin
                    if (vld) begin
                        sh_n = sh_q + SH_W'(1);
                        if (!hdr_ok) begin
                            inv_n = inv_q + INV_W'(1);
                        end
                        if (!hdr_ok && (!lock_q || inv_q == INV_LAST)) begin
                            slip_n  = 1'b1;
                            lock_n  = 1'b0;
                            sh_n    = '0;
                            inv_n   = '0;
                            wt_n    = '0;
                            state_n = ST_SLIP_WAIT;
                        end else if (sh_q == SH_LAST) begin
                            lock_n = 1'b1;
                            sh_n   = '0;
                            inv_n  = '0;
                        end
                    end
                end
                ST_SLIP_WAIT: begin
                    if (vld) begin
                        if (wt_q == WT_LAST) begin
                            wt_n    = '0;
                            sh_n    = '0;
                            inv_n   = '0;
                            state_n = ST_TEST;
                        end else begin
                            wt_n = wt_q + WT_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = ST_LOCK_INIT;
                end
            endcase
            scnt_n = (slip_n && scnt_q != 8'hFF) ? scnt_q + 8'd1 : scnt_q;
        end

        logic       slip_o, lock_o;
        logic [7:0] scnt_o;
        logic [1:0] state_o;

        always_comb begin : lane_out
            slip_o  = slip_q;
            lock_o  = lock_q;
            scnt_o  = scnt_q;
            state_o = state_q;
        end

        assign o_slip[g]           = slip_o;
        assign o_blk_lock[g]       = lock_o;
        assign o_slip_cnt[8*g +: 8] = scnt_o;
        assign o_dbg_state[2*g +: 2] = state_o;
        assign lock_nxt[g]         = lock_n;
    end

    // Registered from next-state lock bits so it rises with the last o_blk_lock.
    always_ff @(posedge i_clk) begin : all_lock_reg
        if (i_reset) begin
            all_lock_q <= 1'b0;
        end else begin
            all_lock_q <= &lock_nxt;
        end
    end

    assign o_all_lock = all_lock_q;

endmodule
